// File: rtl/imem_port_arbiter.sv
// Instruction-memory port arbiter: fetch vs program-loader, loader priority with a starvation bound.
// Optional grant statistics (fetch_cnt/load_cnt) are built when IMEM_ARB_STATS_EN is defined.
module imem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_gnt,
  output logic        fetch_rvalid,
  output logic [31:0] fetch_rdata,
  output logic        fetch_err,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,
  input  logic        ld_lock,
  output logic        ld_gnt,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  state
`ifdef IMEM_ARB_STATS_EN
  ,
  output logic [15:0] fetch_cnt,
  output logic [15:0] load_cnt
`endif
);

  localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    LOAD   = 2'd2,
    LOCKED = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  starve_q, starve_d;
  logic           rvalid_q, rvalid_d;
  logic           err_q, err_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           misaligned;

  assign misaligned = |fetch_addr[1:0];

  // Grants are combinational but forced low while reset is held.
  always_comb begin
    fetch_gnt = 1'b0;
    ld_gnt    = 1'b0;
    state_d   = IDLE;
    starve_d  = starve_q;
    if (rst) begin
      if (ld_lock) begin
        ld_gnt = ld_req;
      end else if (fetch_req && ld_req) begin
        if (starve_q == CW'(STARVE_LIMIT)) fetch_gnt = 1'b1;
        else                               ld_gnt    = 1'b1;
      end else begin
        fetch_gnt = fetch_req;
        ld_gnt    = ld_req;
      end

      if (ld_lock)        state_d = LOCKED;
      else if (fetch_gnt) state_d = FETCH;
      else if (ld_gnt)    state_d = LOAD;
      else                state_d = IDLE;

      // Only unlocked contention that the loader wins counts toward starvation.
      if (fetch_gnt || !fetch_req)
        starve_d = '0;
      else if (!ld_lock && ld_req && ld_gnt && starve_q != CW'(STARVE_LIMIT))
        starve_d = starve_q + CW'(1);
    end
  end

  always_comb begin
    mem_en    = fetch_gnt | ld_gnt;
    mem_we    = ld_gnt;
    mem_addr  = '0;
    mem_wdata = '0;
    if (fetch_gnt) begin
      mem_addr = fetch_addr;
    end else if (ld_gnt) begin
      mem_addr  = ld_addr & ~32'h3;
      mem_wdata = ld_wdata;
    end
  end

  always_comb begin
    rvalid_d = fetch_gnt;
    err_d    = fetch_gnt & misaligned;
    rdata_d  = rdata_q;
    if (fetch_gnt) rdata_d = misaligned ? NOP : mem_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign state        = state_q;
  assign fetch_rvalid = rvalid_q;
  assign fetch_err    = err_q;
  assign fetch_rdata  = rdata_q;

`ifdef IMEM_ARB_STATS_EN
  logic [15:0] fcnt_q, fcnt_d, lcnt_q, lcnt_d;

  always_comb begin
    fcnt_d = fcnt_q;
    lcnt_d = lcnt_q;
    if (fetch_gnt && fcnt_q != 16'hFFFF) fcnt_d = fcnt_q + 16'd1;
    if (ld_gnt && lcnt_q != 16'hFFFF)    lcnt_d = lcnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fcnt_q <= '0;
      lcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
      lcnt_q <= lcnt_d;
    end
  end

  assign fetch_cnt = fcnt_q;
  assign load_cnt  = lcnt_q;
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: transaction-level reference model plus read-response scoreboard.
module tb_imem_port_arbiter;
  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_req = 1'b0, ld_req = 1'b0, ld_lock = 1'b0;
  logic [31:0] fetch_addr = '0, ld_addr = '0, ld_wdata = '0;
  logic        fetch_gnt, fetch_rvalid, fetch_err, ld_gnt, mem_en, mem_we;
  logic [31:0] fetch_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  state;
`ifdef IMEM_ARB_STATS_EN
  logic [15:0] fetch_cnt, load_cnt;
`endif

  imem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata), .fetch_err(fetch_err),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_lock(ld_lock),
    .ld_gnt(ld_gnt), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .state(state)
`ifdef IMEM_ARB_STATS_EN
    , .fetch_cnt(fetch_cnt), .load_cnt(load_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory contents as a pure function of word address; word 2 holds addi x1,x0,5.
  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a[31:2] == 30'd2) return 32'h0050_0093;
    return {a[31:2], 2'b00} ^ 32'hA5C3_0F17;
  endfunction
  assign mem_rdata = memf(mem_addr);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct { int due; logic [31:0] data; logic err; } rsp_t;
  rsp_t        q[$];
  int          m_state = 0, m_starve = 0;
  logic [31:0] m_last = '0;

  // Monitor: pops the expected read response in the cycle it is due.
  always @(negedge clk) begin
    if (rst) begin
      if (q.size() > 0 && q[0].due <= cyc) begin
        chk("rvalid", {31'd0, fetch_rvalid}, 32'd1);
        chk("rdata", fetch_rdata, q[0].data);
        chk("ferr", {31'd0, fetch_err}, {31'd0, q[0].err});
        m_last = q[0].data;
        void'(q.pop_front());
      end else begin
        chk("rvalid_idle", {31'd0, fetch_rvalid}, 32'd0);
        chk("rdata_hold", fetch_rdata, m_last);
      end
    end
  end

  task automatic drive(input logic f, input logic [31:0] fa, input logic l,
                       input logic [31:0] la, input logic [31:0] lw, input logic lk,
                       output logic gf, output logic gl);
    logic ef, el;
    int nst, nsv;
    rsp_t r;
    @(posedge clk); #1;
    fetch_req = f; fetch_addr = fa; ld_req = l; ld_addr = la; ld_wdata = lw; ld_lock = lk;
    ef = 1'b0; el = 1'b0;
    if (lk) begin
      el = l; nst = 3;
    end else begin
      if (f && l) begin
        if (m_starve == LIM) ef = 1'b1; else el = 1'b1;
      end else begin
        ef = f; el = l;
      end
      nst = ef ? 1 : (el ? 2 : 0);
    end
    if (ef || !f)          nsv = 0;
    else if (!lk && f && l) nsv = m_starve + 1;
    else                   nsv = m_starve;
    if (ef) begin
      r.due  = cyc + 1;
      r.err  = (fa[1:0] != 2'b00);
      r.data = r.err ? 32'h0000_0013 : memf(fa);
      q.push_back(r);
    end
    @(negedge clk);
    chk("fetch_gnt", {31'd0, fetch_gnt}, {31'd0, ef});
    chk("ld_gnt", {31'd0, ld_gnt}, {31'd0, el});
    chk("mem_en", {31'd0, mem_en}, {31'd0, ef | el});
    chk("mem_we", {31'd0, mem_we}, {31'd0, el});
    chk("mem_addr", mem_addr, ef ? fa : (el ? {la[31:2], 2'b00} : 32'd0));
    chk("mem_wdata", mem_wdata, el ? lw : 32'd0);
    chk("state", {30'd0, state}, m_state);
    gf = fetch_gnt; gl = ld_gnt;
    m_state = nst; m_starve = nsv;
  endtask

  task automatic idle_inputs();
    fetch_req = 0; ld_req = 0; ld_lock = 0; fetch_addr = '0; ld_addr = '0; ld_wdata = '0;
  endtask

  task automatic enter_reset();
    rst = 1'b0;
    q.delete();
    m_state = 0; m_starve = 0; m_last = '0;
  endtask

  initial begin
    logic gf, gl;
    int nf, nl;
    // Reset with both requesters active: nothing may be granted.
    enter_reset();
    fetch_req = 1; ld_req = 1; fetch_addr = 32'h8; ld_addr = 32'h10;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_fgnt", {31'd0, fetch_gnt}, 32'd0);
    chk("rst_lgnt", {31'd0, ld_gnt}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_rvalid", {31'd0, fetch_rvalid}, 32'd0);
    chk("rst_rdata", fetch_rdata, 32'd0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    idle_inputs();
    @(negedge clk); #2 rst = 1'b1;

    // Aligned fetch of word 2.
    drive(1, 32'h8, 0, 0, 0, 0, gf, gl);
    chk("t35_gnt", {31'd0, gf}, 32'd1);
    drive(0, 0, 0, 0, 0, 0, gf, gl);
    chk("t35_data", fetch_rdata, 32'h0050_0093);

    // Continuous contention: L L L L F repeating.
    nf = 0; nl = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1, 32'h100 + 32'(4 * i), 1, 32'h2000 + 32'(4 * i), $urandom, 0, gf, gl);
      chk("t36_pat", {31'd0, gl}, (i % 5 != 4) ? 32'd1 : 32'd0);
      chk("t36_excl", {31'd0, gf & gl}, 32'd0);
      nf += int'(gf); nl += int'(gl);
    end
    chk("t36_nfetch", nf, 4);
    chk("t36_nload", nl, 16);

    // Lock: loader only, state LOCKED; fetch granted once lock drops.
    nf = 0; nl = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'h40, 1, 32'h3000 + 32'(4 * i), $urandom, 1, gf, gl);
      nf += int'(gf); nl += int'(gl);
    end
    chk("t37_nload", nl, 10);
    chk("t37_nfetch", nf, 0);
    drive(1, 32'h44, 0, 0, 0, 0, gf, gl);
    chk("t37_state", {30'd0, state}, 32'd3);
    chk("t37_fgnt", {31'd0, gf}, 32'd1);

    // Misaligned fetch and loader write.
    drive(1, 32'h6, 0, 0, 0, 0, gf, gl);
    drive(0, 0, 1, 32'h1003, 32'hDEAD_BEEF, 0, gf, gl);
    chk("t38_err", {31'd0, fetch_err}, 32'd1);
    chk("t38_nop", fetch_rdata, 32'h0000_0013);
    chk("t38_addr", mem_addr, 32'h1000);
    chk("t38_we", {31'd0, mem_we}, 32'd1);

    // Reset in the cycle after a fetch grant kills the response at once.
    drive(1, 32'h20, 0, 0, 0, 0, gf, gl);
    @(posedge clk); #1;
    chk("t39_pre", {31'd0, fetch_rvalid}, 32'd1);
    enter_reset();
    #1;
    chk("t39_rvalid", {31'd0, fetch_rvalid}, 32'd0);
    chk("t39_state", {30'd0, state}, 32'd0);
    chk("t39_fgnt", {31'd0, fetch_gnt}, 32'd0);
    idle_inputs();
    @(negedge clk); #2 rst = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic f, l, lk;
      logic [31:0] fa;
      f  = ($urandom_range(0, 3) != 0);
      l  = ($urandom_range(0, 3) != 0);
      lk = ($urandom_range(0, 9) == 0);
      fa = {24'd0, $urandom_range(0, 255) & 8'hFC};
      if ($urandom_range(0, 7) == 0) fa[1:0] = 2'($urandom_range(1, 3));
      drive(f, fa, l, $urandom, $urandom, lk, gf, gl);
      chk("rnd_excl", {31'd0, gf & gl}, 32'd0);
    end

`ifdef IMEM_ARB_STATS_EN
    for (int i = 0; i < 70000; i++) drive(1, 32'h8, 0, 0, 0, 0, gf, gl);
    @(posedge clk); #1;
    chk("stats_sat", {16'd0, fetch_cnt}, 32'h0000_FFFF);
`endif

    drive(0, 0, 0, 0, 0, 0, gf, gl);
    drive(0, 0, 0, 0, 0, 0, gf, gl);
    chk("sb_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_port_arbiter.md
IMEM_PORT_ARBITER -- requirements
Module: imem_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, SHALL be the maximum number of consecutive contended cycles the loader wins before fetch is granted.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 fetch_req  input  1  fetch stage requests a read this cycle.
REQ-005 fetch_addr  input  32  byte address of the fetch.
REQ-006 fetch_gnt  output  1  fetch request accepted this cycle (combinational).
REQ-007 fetch_rvalid  output  1  registered read data valid, one-cycle pulse.
REQ-008 fetch_rdata  output  32  registered instruction word.
REQ-009 fetch_err  output  1  registered misaligned-fetch flag, aligned with fetch_rvalid.
REQ-010 ld_req  input  1  program loader requests a word write this cycle.
REQ-011 ld_addr  input  32  byte address of the write.
REQ-012 ld_wdata  input  32  write data.
REQ-013 ld_lock  input  1  loader holds exclusive ownership; fetch is never granted.
REQ-014 ld_gnt  output  1  loader write accepted this cycle (combinational).
REQ-015 mem_en  output  1  memory access strobe; mem_we  output  1  write strobe.
REQ-016 mem_addr  output  32  byte address to memory, which indexes words with bits [31:2]; mem_wdata  output  32.
REQ-017 mem_rdata  input  32  combinational memory read data.
REQ-018 state  output  2  current arbitration state: 0 IDLE, 1 FETCH, 2 LOAD, 3 LOCKED.

Function
REQ-019 At most one of fetch_gnt and ld_gnt SHALL be high in any cycle.
REQ-020 If ld_lock is high, the block SHALL grant ld_req only, and the next state SHALL be LOCKED.
REQ-021 If only one requester is active and not blocked by ld_lock, that requester SHALL be granted.
REQ-022 On contention without lock, the loader SHALL win, unless starve_cnt equals STARVE_LIMIT, in which case fetch SHALL win.
REQ-023 starve_cnt SHALL increment on each contended cycle the loader wins; it SHALL clear when fetch is granted or fetch_req is low. It SHALL never exceed STARVE_LIMIT.
REQ-024 Next state SHALL be FETCH, LOAD or IDLE according to the grant given, or LOCKED per REQ-020.
REQ-025 On a fetch grant: mem_en=1, mem_we=0, mem_addr=fetch_addr. mem_rdata SHALL be captured into fetch_rdata, and fetch_rvalid SHALL be high in the next cycle only.
REQ-026 On a loader grant: mem_en=1, mem_we=1, mem_addr=ld_addr, mem_wdata=ld_wdata; no read response is produced.
REQ-027 With no grant, mem_en=0, mem_we=0, mem_addr=0, and mem_wdata=0.
REQ-028 A fetch with fetch_addr[1:0]!=0 SHALL still be granted. The response SHALL carry fetch_rdata=32'h00000013 (nop) and fetch_err=1; memory data is ignored.
REQ-029 A loader request with ld_addr[1:0]!=0 SHALL be granted, and its write SHALL be word-aligned by forcing mem_addr[1:0]=0.
REQ-030 fetch_rdata SHALL hold its last value while fetch_rvalid is low.

Reset
REQ-031 While rst is low, the block SHALL drive state=IDLE, starve_cnt=0, fetch_rvalid=0, fetch_err=0, fetch_rdata=0, and all grants and mem strobes low, regardless of request inputs.
REQ-032 Reset asserted mid-access SHALL drop any pending fetch_rvalid. The first grant SHALL be evaluated on the first rising edge after rst deasserts.

Configuration
REQ-033 With macro IMEM_ARB_STATS_EN defined, the block SHALL add outputs fetch_cnt [15:0] and load_cnt [15:0]. Each SHALL count grants, saturate at 16'hFFFF, and reset to 0.
REQ-034 Without IMEM_ARB_STATS_EN, these outputs and their counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-035 Fetch only, fetch_addr=0x8 with mem_rdata=0x00500093 -> fetch_gnt=1, mem_addr=0x8, and the next cycle has fetch_rvalid=1 with fetch_rdata=0x00500093.
REQ-036 Continuous contention, STARVE_LIMIT=4 -> ld_gnt for 4 cycles, then fetch_gnt for 1 cycle, repeating; the grants are never simultaneous.
REQ-037 ld_lock=1 with both requesting for 10 cycles -> 10 ld_gnt, 0 fetch_gnt, state=LOCKED; the cycle after ld_lock drops -> fetch_gnt=1 with ld_req low.
REQ-038 Fetch at 0x6 -> fetch_err=1 and fetch_rdata=0x00000013 the next cycle; loader at ld_addr=0x1003 -> mem_addr=0x1000 with mem_we=1.
REQ-039 rst pulsed low in the cycle after a fetch grant -> fetch_rvalid stays 0 and state=IDLE immediately, without a clock edge.
REQ-040 With IMEM_ARB_STATS_EN defined, 70000 fetch grants -> fetch_cnt=16'hFFFF.
